spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Command-decoding memory that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit received word (2-bit opcode plus 8-bit payload) on rx_valid.
- Maintains separate write and read address pointers in a synchronous byte RAM.
- Returns read bytes to the slave as tx_data/tx_valid, holding tx_valid long enough for an 8-bit MISO shift-out.

Parameters:
MEM_DEPTH, 256, number of byte locations; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_SIZE
ADDR_SIZE, 8, pointer width; payload bits [ADDR_SIZE-1:0] carry addresses
AUTO_INC, 0, when 1 the write pointer advances after each write-data and the read pointer after each read-data
TX_HOLD, 8, cycles tx_valid stays high after a read-data command (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
rx_data  input  10  command word from SPI slave: [9:8] opcode, [7:0] payload
rx_valid  input  1  single-cycle strobe, rx_data is valid
tx_data  output  8  read byte to SPI slave
tx_valid  output  1  tx_data is valid for shift-out
wr_ptr  output  ADDR_SIZE  current write pointer (debug/observability)
rd_ptr  output  ADDR_SIZE  current read pointer (debug/observability)

Behaviour:
- Reset (rst low, async): tx_data=0, tx_valid=0, wr_ptr=0, rd_ptr=0, hold counter=0. RAM contents are not reset and are undefined until written.
- Commands are accepted only on clock edges where rx_valid=1. rx_data is ignored when rx_valid=0.
- Opcode 2'b00 (WR_ADDR): wr_ptr <= rx_data[ADDR_SIZE-1:0].
- Opcode 2'b01 (WR_DATA): mem[wr_ptr] <= rx_data[7:0].
  - If wr_ptr >= MEM_DEPTH the write is dropped silently.
  - If AUTO_INC=1, wr_ptr advances; MEM_DEPTH-1 wraps to 0, and an out-of-range pointer also wraps to 0.
- Opcode 2'b10 (RD_ADDR): rd_ptr <= rx_data[ADDR_SIZE-1:0]. Payload bits above ADDR_SIZE are ignored for both address opcodes.
- Opcode 2'b11 (RD_DATA): payload is ignored.
  - tx_data <= mem[rd_ptr], or 8'h00 if rd_ptr >= MEM_DEPTH.
  - tx_valid <= 1 and the hold counter is loaded with TX_HOLD.
  - If AUTO_INC=1, rd_ptr advances with the same wrap rule as wr_ptr.
- Latency: with rx_valid high at edge N, tx_data and tx_valid are valid after edge N (one cycle). Written data is readable by an RD_DATA at edge N+1.
- tx_valid hold:
  - The counter decrements each cycle while nonzero; tx_valid is 1 exactly while the counter is nonzero, giving TX_HOLD cycles.
  - tx_data remains stable after tx_valid drops.
- RD_DATA during an active hold: tx_data is reloaded with the new byte and the counter is reloaded to TX_HOLD, so tx_valid stays high continuously.
- Other opcodes during a hold leave tx_valid, tx_data and the counter untouched.
- Only one command per cycle is possible, so there are no intra-cycle read/write hazards.
- RAM is a single-write, single-read synchronous array. The read occurs on the RD_DATA edge, using rd_ptr before any auto-increment.

Decomposition:
- Shared package spi_pkg: opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11, and RX_W=10. The SPI slave uses the same package.
- Sub-module spi_ram_mem: parameterised byte array (MEM_DEPTH x 8) with write enable/address/data and synchronous read enable/address/data. No reset.
- spi_ram_ctrl holds the opcode decode, pointers, range checks, and the hold counter.

Test Plan:
- Basic write/read, defaults:
  - Stimulus: rx_valid strobes with 0x012 (WR_ADDR 0x12), 0x1A5 (WR_DATA 0xA5), 0x212 (RD_ADDR 0x12), 0x300 (RD_DATA).
  - Response: tx_data=0xA5 one cycle after the last strobe; tx_valid high exactly 8 cycles, then low with tx_data still 0xA5.
- AUTO_INC=1 with wrap:
  - Stimulus: WR_ADDR 0xFE; WR_DATA 0x11, 0x22, 0x33; RD_ADDR 0xFE; three RD_DATA.
  - Response: tx_data sequence 0x11, 0x22, 0x33 (locations FE, FF, 00); wr_ptr=0x01 and rd_ptr=0x01 at the end.
- Out of range, MEM_DEPTH=200:
  - Stimulus: WR_ADDR 0xC8; WR_DATA 0x5A; RD_ADDR 0xC8; RD_DATA.
  - Response: tx_data=0x00, and location 0x00 is not modified.
- Back-to-back read retrigger:
  - Stimulus: two RD_DATA 3 cycles apart from locations holding 0x0F and 0xF0.
  - Response: tx_valid high continuously for 3+8=11 cycles; tx_data changes from 0x0F to 0xF0 at the second strobe.
- Ignore and reset:
  - Stimulus: toggle rx_data with rx_valid=0.
  - Response: no pointer or tx change.
  - Stimulus: assert rst low mid-hold, asynchronous to clk.
  - Response: tx_valid=0, tx_data=0, wr_ptr=rd_ptr=0 immediately; tx_valid stays low after release until the next RD_DATA.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcode encodings and the received-word layout
// used by both the SPI slave and the RAM controller.
package spi_pkg;

  localparam int RX_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Byte RAM, MEM_DEPTH x 8, one synchronous write port and one synchronous read
// port. Contents are never reset; the caller keeps addresses in range.
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [MEM_DEPTH];

  // rd_data holds its last value between reads so the shifted-out byte stays put.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between the SPI slave and a byte RAM: separate write/read
// pointers, out-of-range filtering, and a tx_valid hold window for shift-out.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0,
  parameter int TX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RX_W-1:0]      rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] wr_ptr,
  output logic [ADDR_SIZE-1:0] rd_ptr
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; every
  // strobed word is consumed on that edge. tx_valid is a level with no ready:
  // it stays high for TX_HOLD cycles after the latest RD_DATA.

  localparam int             HOLD_W    = $clog2(TX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(TX_HOLD);
  localparam logic [31:0]    DEPTH_U   = 32'(MEM_DEPTH);

  cmd_t                 cmd;
  logic                 is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;
  logic                 wr_in_range, rd_in_range;
  logic [ADDR_SIZE-1:0] addr_payload;
  logic [7:0]           mem_rd_data;
  logic                 tx_loaded, tx_oor;
  logic [HOLD_W-1:0]    hold_cnt;

  // Last valid location and any out-of-range pointer both wrap to zero.
  function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] p);
    if (32'(p) >= DEPTH_U - 32'd1) return '0;
    else return p + 1'b1;
  endfunction

  assign cmd          = rx_data;
  assign addr_payload = cmd.payload[ADDR_SIZE-1:0];
  assign is_wr_addr   = rx_valid && (cmd.op == CMD_WR_ADDR);
  assign is_wr_data   = rx_valid && (cmd.op == CMD_WR_DATA);
  assign is_rd_addr   = rx_valid && (cmd.op == CMD_RD_ADDR);
  assign is_rd_data   = rx_valid && (cmd.op == CMD_RD_DATA);
  assign wr_in_range  = 32'(wr_ptr) < DEPTH_U;
  assign rd_in_range  = 32'(rd_ptr) < DEPTH_U;

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (is_wr_data && wr_in_range),
    .wr_addr (wr_ptr),
    .wr_data (cmd.payload),
    .rd_en   (is_rd_data && rd_in_range),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (is_wr_addr) begin
      wr_ptr <= addr_payload;
    end else if (is_wr_data && (AUTO_INC != 0)) begin
      wr_ptr <= bump(wr_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (is_rd_addr) begin
      rd_ptr <= addr_payload;
    end else if (is_rd_data && (AUTO_INC != 0)) begin
      rd_ptr <= bump(rd_ptr);
    end
  end

  // The RAM has no reset, so tx_data is gated to zero until the first read
  // and forced to zero when that read targeted an out-of-range location.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_loaded <= 1'b0;
      tx_oor    <= 1'b0;
      hold_cnt  <= '0;
    end else if (is_rd_data) begin
      tx_loaded <= 1'b1;
      tx_oor    <= !rd_in_range;
      hold_cnt  <= HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_cnt  <= hold_cnt - 1'b1;
    end
  end

  assign tx_data  = (tx_loaded && !tx_oor) ? mem_rd_data : 8'h00;
  assign tx_valid = (hold_cnt != '0);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three differently parameterised instances share one
// command stream and are checked every cycle against a behavioural model.
module tb_spi_ram_ctrl;
  import spi_pkg::*;

  localparam int N = 3;
  localparam int DEPTH_P [N] = '{256, 256, 200};
  localparam int AUTO_P  [N] = '{0, 1, 1};
  localparam int HOLD_P  [N] = '{8, 8, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]          rx_data  = '0;
  logic                rx_valid = 1'b0;
  logic [N-1:0][7:0]   tx_data_a;
  logic [N-1:0]        tx_valid_a;
  logic [N-1:0][7:0]   wr_ptr_a;
  logic [N-1:0][7:0]   rd_ptr_a;

  spi_ram_ctrl u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
    .wr_ptr(wr_ptr_a[0]), .rd_ptr(rd_ptr_a[0])
  );

  spi_ram_ctrl #(.AUTO_INC(1)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
    .wr_ptr(wr_ptr_a[1]), .rd_ptr(rd_ptr_a[1])
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .AUTO_INC(1), .TX_HOLD(3)) u2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]),
    .wr_ptr(wr_ptr_a[2]), .rd_ptr(rd_ptr_a[2])
  );

  // ---------------- scoreboard counters ----------------
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string nm, input int inst, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s[u%0d] at %0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mem_m   [N][256];
  bit known_m [N][256];
  int wr_m [N], rd_m [N], txd_m [N], last_rd [N];
  bit txk_m [N], has_rd [N];
  int cyc;

  initial begin
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 256; a++) known_m[i][a] = 1'b0;
  end

  function automatic int next_ptr(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0;
      for (int i = 0; i < N; i++) begin
        wr_m[i] = 0; rd_m[i] = 0; txd_m[i] = 0; txk_m[i] = 1'b1;
        has_rd[i] = 1'b0; last_rd[i] = 0;
      end
    end else begin
      cyc++;
      if (rx_valid) begin
        for (int i = 0; i < N; i++) begin
          int pl;
          pl = int'(rx_data[7:0]);
          case (rx_data[9:8])
            CMD_WR_ADDR: wr_m[i] = pl;
            CMD_WR_DATA: begin
              if (wr_m[i] < DEPTH_P[i]) begin
                mem_m[i][wr_m[i]] = pl;
                known_m[i][wr_m[i]] = 1'b1;
              end
              if (AUTO_P[i] != 0) wr_m[i] = next_ptr(wr_m[i], DEPTH_P[i]);
            end
            CMD_RD_ADDR: rd_m[i] = pl;
            default: begin
              if (rd_m[i] < DEPTH_P[i]) begin
                txd_m[i] = mem_m[i][rd_m[i]];
                txk_m[i] = known_m[i][rd_m[i]];
              end else begin
                txd_m[i] = 0;
                txk_m[i] = 1'b1;
              end
              has_rd[i]  = 1'b1;
              last_rd[i] = cyc;
              if (AUTO_P[i] != 0) rd_m[i] = next_ptr(rd_m[i], DEPTH_P[i]);
            end
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int exp_v;
      exp_v = (has_rd[i] && (cyc - last_rd[i] < HOLD_P[i])) ? 1 : 0;
      check("tx_valid", i, int'(tx_valid_a[i]), exp_v);
      if (txk_m[i]) check("tx_data", i, int'(tx_data_a[i]), txd_m[i]);
      check("wr_ptr", i, int'(wr_ptr_a[i]), wr_m[i]);
      check("rd_ptr", i, int'(rd_ptr_a[i]), rd_m[i]);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rx_data = 10'($urandom_range(0, 1023));
      @(negedge clk);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int hi;
    @(negedge clk);
    check("reset_tx_valid", 0, int'(tx_valid_a[0]), 0);
    check("reset_tx_data", 0, int'(tx_data_a[0]), 0);
    check("reset_wr_ptr", 2, int'(wr_ptr_a[2]), 0);
    check("reset_rd_ptr", 2, int'(rd_ptr_a[2]), 0);
    rst = 1'b1;
    idle(2);

    // Basic write/read with defaults.
    send(CMD_WR_ADDR, 8'h12);
    send(CMD_WR_DATA, 8'hA5);
    send(CMD_RD_ADDR, 8'h12);
    send(CMD_RD_DATA, 8'h00);
    check("basic_data", 0, int'(tx_data_a[0]), 8'hA5);
    hi = int'(tx_valid_a[0]);
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (!tx_valid_a[0]) break;
      hi++;
    end
    check("basic_hold_len", 0, hi, 8);
    check("basic_data_after", 0, int'(tx_data_a[0]), 8'hA5);

    // Auto-increment across the top of the address space.
    send(CMD_WR_ADDR, 8'hFE);
    send(CMD_WR_DATA, 8'h11);
    send(CMD_WR_DATA, 8'h22);
    send(CMD_WR_DATA, 8'h33);
    send(CMD_RD_ADDR, 8'hFE);
    send(CMD_RD_DATA, 8'h00);
    check("wrap_rd0", 1, int'(tx_data_a[1]), 8'h11);
    send(CMD_RD_DATA, 8'h00);
    check("wrap_rd1", 1, int'(tx_data_a[1]), 8'h22);
    send(CMD_RD_DATA, 8'h00);
    check("wrap_rd2", 1, int'(tx_data_a[1]), 8'h33);
    check("wrap_wr_ptr", 1, int'(wr_ptr_a[1]), 8'h01);
    check("wrap_rd_ptr", 1, int'(rd_ptr_a[1]), 8'h01);
    idle(10);

    // Out-of-range access on the 200-deep instance.
    send(CMD_WR_ADDR, 8'h00);
    send(CMD_WR_DATA, 8'h77);
    send(CMD_WR_ADDR, 8'hC8);
    send(CMD_WR_DATA, 8'h5A);
    send(CMD_RD_ADDR, 8'hC8);
    send(CMD_RD_DATA, 8'h00);
    check("oor_data", 2, int'(tx_data_a[2]), 8'h00);
    check("oor_wrap_rd", 2, int'(rd_ptr_a[2]), 8'h00);
    send(CMD_RD_DATA, 8'h00);
    check("oor_loc0_kept", 2, int'(tx_data_a[2]), 8'h77);
    idle(10);

    // Back-to-back read retrigger.
    send(CMD_WR_ADDR, 8'h20);
    send(CMD_WR_DATA, 8'h0F);
    send(CMD_WR_ADDR, 8'h21);
    send(CMD_WR_DATA, 8'hF0);
    send(CMD_RD_ADDR, 8'h20);
    send(CMD_RD_DATA, 8'h00);
    check("retrig_first", 0, int'(tx_data_a[0]), 8'h0F);
    hi = int'(tx_valid_a[0]);
    send(CMD_RD_ADDR, 8'h21);
    hi += int'(tx_valid_a[0]);
    idle(1);
    hi += int'(tx_valid_a[0]);
    send(CMD_RD_DATA, 8'h00);
    check("retrig_second", 0, int'(tx_data_a[0]), 8'hF0);
    hi += int'(tx_valid_a[0]);
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (!tx_valid_a[0]) break;
      hi++;
    end
    check("retrig_hold_len", 0, hi, 11);

    // rx_data toggling without rx_valid must not change anything.
    idle(12);
    check("ignore_wr_ptr", 0, int'(wr_ptr_a[0]), 8'h21);
    check("ignore_rd_ptr", 0, int'(rd_ptr_a[0]), 8'h21);
    check("ignore_tx_valid", 0, int'(tx_valid_a[0]), 0);
    check("ignore_tx_data", 0, int'(tx_data_a[0]), 8'hF0);

    // Asynchronous reset in the middle of a hold window.
    send(CMD_RD_DATA, 8'h00);
    idle(2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_tx_valid", 0, int'(tx_valid_a[0]), 0);
    check("arst_tx_data", 0, int'(tx_data_a[0]), 0);
    check("arst_wr_ptr", 0, int'(wr_ptr_a[0]), 0);
    check("arst_rd_ptr", 0, int'(rd_ptr_a[0]), 0);
    @(negedge clk);
    idle(1);
    rst = 1'b1;
    idle(4);
    check("post_rst_tx_valid", 0, int'(tx_valid_a[0]), 0);
    check("post_rst_tx_valid", 1, int'(tx_valid_a[1]), 0);

    // Randomised command stream with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [1:0] op;
      logic [7:0] pl;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 799) == 0) begin
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else if (r < 7) begin
        op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) pl = 8'($urandom_range(190, 255));
        else pl = 8'($urandom_range(0, 255));
        send(op, pl);
      end else begin
        idle(1);
      end
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
